// File: rtl/tdm_demux_1x8_pkg.sv
// Shared definitions for the 8:1 TDM link (receive side).
// Holds the default frame geometry and the framing-FSM state encodings, which are
// also used by the transmitter so both ends agree on the link layout.
package tdm_demux_1x8_pkg;

  // Default frame geometry: 8 slots, 3-bit slot index.
  localparam int unsigned TDM_NUM_CH = 8;
  localparam int unsigned TDM_SEL_W  = 3;

  // Framing state. Kept as plain constants so legacy code can share the encoding.
  typedef logic tdm_state_t;
  localparam tdm_state_t ST_HUNT = 1'b0;
  localparam tdm_state_t ST_LOCK = 1'b1;

endpackage

// File: rtl/tdm_demux_1x8_slot_counter.sv
// Slot counter for the TDM demultiplexer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance slot by one (natural modulo-2^SEL_W wrap)
//   load1      : force slot to 1 (current cycle was slot 0)
//   clr        : force slot to 0; highest priority
//   slot       : current slot index
//   last       : slot is the final slot of the frame (NUM_CH-1)
module tdm_demux_1x8_slot_counter #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load1,
  input  logic             clr,
  output logic [SEL_W-1:0] slot,
  output logic             last
);

  logic [SEL_W-1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SEL_W'(1);
    end else if (en) begin
      slot_d = slot_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == SEL_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux_1x8.sv
// Receive end of the 8:1 time-division link.
// One sample arrives per enabled cycle on din; frame_sync marks slot 0. Slots
// 0..NUM_CH-2 are collected in a shadow bank; the final slot is merged with the
// shadow bank straight into the publish register, so dout only ever shows
// complete frames and updates on the same edge that samples the last slot.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : slot strobe; frame_sync/din are ignored while low
//   frame_sync  : current din is slot 0
//   din         : slot sample
//   dout        : published frame, channel k at dout[k*DATA_W +: DATA_W]
//   frame_valid : one-cycle pulse, dout updated this cycle
//   slot        : slot index the next enabled sample will be written to
//   locked      : framing FSM is in LOCK
//   sync_err    : one-cycle pulse on a framing violation (early or missing sync)
module tdm_demux_1x8
  import tdm_demux_1x8_pkg::*;
#(
  parameter int unsigned NUM_CH = TDM_NUM_CH,
  parameter int unsigned SEL_W  = TDM_SEL_W,
  parameter int unsigned DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     frame_sync,
  input  logic [DATA_W-1:0]        din,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     frame_valid,
  output logic [SEL_W-1:0]         slot,
  output logic                     locked,
  output logic                     sync_err
);

  localparam int unsigned ShadowW = (NUM_CH - 1) * DATA_W;

  tdm_state_t                state_q, state_d;
  logic [ShadowW-1:0]        shadow_q, shadow_d;
  logic [NUM_CH*DATA_W-1:0]  dout_q, dout_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      sync_err_q, sync_err_d;

  logic                      cnt_inc;
  logic                      cnt_load1;
  logic                      cnt_clr;
  logic [SEL_W-1:0]          slot_cur;
  logic                      slot_last;

  tdm_demux_1x8_slot_counter #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .slot  (slot_cur),
    .last  (slot_last)
  );

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    cnt_inc       = 1'b0;
    cnt_load1     = 1'b0;
    cnt_clr       = 1'b0;

    if (en) begin
      if (state_q == ST_HUNT) begin
        // Slot stays at 0 while hunting; only a sync lets us start a frame.
        if (frame_sync) begin
          shadow_d[DATA_W-1:0] = din;
          cnt_load1            = 1'b1;
          state_d              = ST_LOCK;
        end
      end else begin
        if (frame_sync) begin
          // Sync anywhere but slot 0 abandons the partial frame (never published)
          // and restarts collection with this sample as slot 0.
          if (slot_cur != '0) begin
            sync_err_d = 1'b1;
          end
          shadow_d[DATA_W-1:0] = din;
          cnt_load1            = 1'b1;
        end else if (slot_cur == '0) begin
          sync_err_d = 1'b1;
          cnt_clr    = 1'b1;
          state_d    = ST_HUNT;
        end else if (slot_last) begin
          dout_d        = {din, shadow_q};
          frame_valid_d = 1'b1;
          cnt_inc       = 1'b1;  // wraps to 0
        end else begin
          for (int k = 1; k < int'(NUM_CH) - 1; k++) begin
            if (slot_cur == SEL_W'(k)) begin
              shadow_d[k*DATA_W +: DATA_W] = din;
            end
          end
          cnt_inc = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HUNT;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign dout        = dout_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_cur;
  assign locked      = (state_q == ST_LOCK);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
module tb_tdm_demux_1x8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       frame_sync;
  logic [0:0] din;
  logic [7:0] dout;
  logic       frame_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int n_checks = 0;
  int n_errors = 0;

  tdm_demux_1x8 #(
    .NUM_CH (8),
    .SEL_W  (3),
    .DATA_W (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .frame_sync  (frame_sync),
    .din         (din),
    .dout        (dout),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected post-edge view of the outputs for one driven cycle.
  typedef struct {
    logic [7:0] dout;
    logic       fv;
    logic       se;
    logic [2:0] slot;
    logic       locked;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: receiver framing rules in terms of a position counter
  // and an array of collected samples.
  bit         m_locked;
  int         m_pos;
  bit         m_buf[8];
  logic [7:0] m_dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_dout   = '0;
    foreach (m_buf[i]) m_buf[i] = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit d);
    exp_t x;
    x.fv = 1'b0;
    x.se = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (s) begin
          m_buf[0] = d;
          m_pos    = 1;
          m_locked = 1'b1;
        end
      end else if (s) begin
        if (m_pos != 0) x.se = 1'b1;
        m_buf[0] = d;
        m_pos    = 1;
      end else if (m_pos == 0) begin
        x.se     = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_buf[m_pos] = d;
        if (m_pos == 7) begin
          for (int k = 0; k < 8; k++) m_dout[k] = m_buf[k];
          x.fv  = 1'b1;
          m_pos = 0;
        end else begin
          m_pos = m_pos + 1;
        end
      end
    end
    x.dout   = m_dout;
    x.slot   = 3'(m_pos);
    x.locked = m_locked;
    exp_q.push_back(x);
  endtask

  // Drive one cycle of stimulus; the expectation is queued for the monitor.
  task automatic cycle(input bit e, input bit s, input bit d);
    @(negedge clk);
    en         = e;
    frame_sync = s;
    din        = d;
    model_step(e, s, d);
  endtask

  // Wait until just after the edge that consumed the last driven cycle.
  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic send_frame(input logic [7:0] f);
    for (int k = 0; k < 8; k++) cycle(1'b1, k == 0, f[k]);
  endtask

  // Monitor: compares every post-edge output against the queued expectation.
  always @(posedge clk) begin
    #2;
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dout",        {24'h0, dout},      {24'h0, mon_e.dout});
      chk("frame_valid", {31'h0, frame_valid}, {31'h0, mon_e.fv});
      chk("sync_err",    {31'h0, sync_err},  {31'h0, mon_e.se});
      chk("slot",        {29'h0, slot},      {29'h0, mon_e.slot});
      chk("locked",      {31'h0, locked},    {31'h0, mon_e.locked});
    end
  end

  initial begin
    logic [7:0] f;
    bit         e;
    bit         s;
    rst_n      = 1'b0;
    en         = 1'b0;
    frame_sync = 1'b0;
    din        = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_dout",   {24'h0, dout}, 32'h0);
    chk("rst_slot",   {29'h0, slot}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    chk("rst_fv",     {31'h0, frame_valid}, 32'h0);

    // Clean frame: slot samples 1,0,1,1,0,0,1,0.
    send_frame(8'b0100_1101);
    settle();
    chk("clean_dout",   {24'h0, dout}, 32'h4d);
    chk("clean_fv",     {31'h0, frame_valid}, 32'h1);
    chk("clean_slot",   {29'h0, slot}, 32'h0);
    chk("clean_locked", {31'h0, locked}, 32'h1);

    // Gapped enable: 3 idle cycles after slot 3 with garbage on inputs.
    f = 8'b0100_1101;
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, f[k]);
    for (int g = 0; g < 3; g++) begin
      cycle(1'b0, 1'b1, 1'b1);
      settle();
      chk("gap_slot", {29'h0, slot}, 32'h4);
      chk("gap_fv",   {31'h0, frame_valid}, 32'h0);
    end
    for (int k = 4; k < 8; k++) cycle(1'b1, 1'b0, f[k]);
    settle();
    chk("gap_dout", {24'h0, dout}, 32'h4d);
    chk("gap_fv_end", {31'h0, frame_valid}, 32'h1);

    // Early sync at slot 5, then a fresh frame 0xA5 completed by 7 more samples.
    for (int k = 0; k < 5; k++) cycle(1'b1, k == 0, 1'b0);
    f = 8'hA5;
    cycle(1'b1, 1'b1, f[0]);
    settle();
    chk("early_se",   {31'h0, sync_err}, 32'h1);
    chk("early_slot", {29'h0, slot}, 32'h1);
    chk("early_dout", {24'h0, dout}, 32'h4d);
    for (int k = 1; k < 8; k++) cycle(1'b1, 1'b0, f[k]);
    settle();
    chk("early_new_dout", {24'h0, dout}, 32'ha5);

    // Missing sync at slot 0, then ignored samples while hunting.
    cycle(1'b1, 1'b0, 1'b1);
    settle();
    chk("miss_se",     {31'h0, sync_err}, 32'h1);
    chk("miss_locked", {31'h0, locked}, 32'h0);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 1'b1);
    settle();
    chk("hunt_slot", {29'h0, slot}, 32'h0);
    chk("hunt_dout", {24'h0, dout}, 32'ha5);

    // Streaming: 4 back-to-back frames.
    for (int n = 0; n < 4; n++) begin
      f = 8'($urandom);
      send_frame(f);
      settle();
      chk("stream_dout", {24'h0, dout}, {24'h0, f});
    end

    // Randomised traffic with occasional framing faults.
    for (int n = 0; n < 1500; n++) begin
      e = ($urandom_range(0, 3) != 0);
      if (m_locked) s = (m_pos == 0) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 30) == 0);
      else          s = ($urandom_range(0, 3) == 0);
      cycle(e, s, 1'($urandom));
    end

    // Reset mid-frame: outputs must clear without waiting for a clock edge.
    send_frame(8'h3c);
    for (int k = 0; k < 3; k++) cycle(1'b1, k == 0, 1'b1);
    settle();
    rst_n = 1'b0;
    #1;
    chk("midrst_dout",   {24'h0, dout}, 32'h0);
    chk("midrst_slot",   {29'h0, slot}, 32'h0);
    chk("midrst_locked", {31'h0, locked}, 32'h0);
    chk("midrst_fv",     {31'h0, frame_valid}, 32'h0);
    chk("midrst_se",     {31'h0, sync_err}, 32'h0);
    exp_q.delete();
    model_reset();
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    send_frame(8'h96);
    settle();
    chk("post_rst_dout", {24'h0, dout}, 32'h96);

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
